snake_dir_queue: RTL and testbench



---
 rtl/snake_dir_queue.sv | 150 +++++++++++++++
 tb/tb_snake_dir_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_queue.sv
// ============================================================================
// snake_dir_queue : PS/2 scan-code parser feeding a direction FIFO for Snake
// Rev 1.0
// ============================================================================
`default_nettype none

module snake_dir_queue #(
  parameter int         DEPTH      = 4,
  parameter bit         ALLOW_WASD = 1'b1,
  parameter bit         REQUIRE_E0 = 1'b1,
  parameter logic [2:0] INIT_DIR   = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               key_code,
  input  logic                     key_valid,
  input  logic                     tick,
  input  logic                     clear,
  output logic [2:0]               movement,
  output logic                     moved,
  output logic                     dropped,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    queue [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;

  logic          is_arrow;
  logic          is_wasd;
  logic [1:0]    arrow_dir;
  logic [1:0]    wasd_dir;
  logic          cand_valid;
  logic [1:0]    cand_dir;
  logic [1:0]    ref_dir;
  logic          full;
  logic          pop;
  logic          accept;
  logic          push;
  logic          overflow;

  always_comb begin
    is_arrow  = 1'b0;
    is_wasd   = 1'b0;
    arrow_dir = 2'b00;
    wasd_dir  = 2'b00;
    case (key_code)
      8'h74: begin is_arrow = 1'b1; arrow_dir = 2'b00; end
      8'h75: begin is_arrow = 1'b1; arrow_dir = 2'b01; end
      8'h6B: begin is_arrow = 1'b1; arrow_dir = 2'b10; end
      8'h72: begin is_arrow = 1'b1; arrow_dir = 2'b11; end
      8'h23: begin is_wasd  = 1'b1; wasd_dir  = 2'b00; end
      8'h1D: begin is_wasd  = 1'b1; wasd_dir  = 2'b01; end
      8'h1C: begin is_wasd  = 1'b1; wasd_dir  = 2'b10; end
      8'h1B: begin is_wasd  = 1'b1; wasd_dir  = 2'b11; end
      default: ;
    endcase
  end

  // Parser: break sequences swallow exactly one following byte.
  always_comb begin
    state_nxt  = state;
    cand_valid = 1'b0;
    cand_dir   = arrow_dir;
    if (key_valid) begin
      case (state)
        IDLE: begin
          if (key_code == 8'hE0) begin
            state_nxt = EXT;
          end else if (key_code == 8'hF0) begin
            state_nxt = BRK;
          end else if (ALLOW_WASD && is_wasd) begin
            cand_valid = 1'b1;
            cand_dir   = wasd_dir;
          end else if (!REQUIRE_E0 && is_arrow) begin
            cand_valid = 1'b1;
          end
        end
        EXT: begin
          state_nxt = IDLE;
          if (key_code == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else if (is_arrow) begin
            cand_valid = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reference is taken before any same-edge pop.
  assign tail_ptr = wr_ptr - 1'b1;
  assign ref_dir  = (q_count != '0) ? queue[tail_ptr] : movement[1:0];
  assign full     = (q_count == (AW+1)'(DEPTH));
  assign pop      = tick && (q_count != '0);
  assign accept   = cand_valid && (cand_dir != ref_dir) &&
                    !((cand_dir[1] != ref_dir[1]) && (cand_dir[0] == ref_dir[0]));
  assign push     = accept && (!full || pop);
  assign overflow = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      movement <= INIT_DIR;
      moved    <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        movement <= {1'b0, queue[rd_ptr]};
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      moved   <= pop;
      dropped <= overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !clear && push) begin
      queue[wr_ptr] <= cand_dir;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snake_dir_queue.sv
// ============================================================================
// tb_snake_dir_queue : scenario tasks plus randomized run against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_snake_dir_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] key_code;
  logic       key_valid;
  logic       tick;
  logic       clear;
  logic [2:0] movement;
  logic       moved;
  logic       dropped;
  logic [2:0] q_count;
  logic [2:0] movement2;
  logic       moved2;
  logic       dropped2;
  logic [2:0] q_count2;

  int checks = 0;
  int errors = 0;

  // Reference model for the default-parameter instance
  logic [1:0] mq[$];
  logic [2:0] mmov;
  bit         mmoved;
  bit         mdropped;
  bit         mext;
  bit         mskip;

  always #5 clk = ~clk;

  snake_dir_queue #(.DEPTH(DEPTH), .ALLOW_WASD(1'b1), .REQUIRE_E0(1'b1), .INIT_DIR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .key_code(key_code), .key_valid(key_valid),
    .tick(tick), .clear(clear), .movement(movement), .moved(moved),
    .dropped(dropped), .q_count(q_count)
  );

  snake_dir_queue #(.DEPTH(DEPTH), .ALLOW_WASD(1'b1), .REQUIRE_E0(1'b0), .INIT_DIR(3'b000)) dut2 (
    .clk(clk), .resetn(resetn), .key_code(key_code), .key_valid(key_valid),
    .tick(tick), .clear(clear), .movement(movement2), .moved(moved2),
    .dropped(dropped2), .q_count(q_count2)
  );

  function automatic int arrow_idx(input logic [7:0] c);
    case (c)
      8'h74: return 0;
      8'h75: return 1;
      8'h6B: return 2;
      8'h72: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_idx(input logic [7:0] c);
    case (c)
      8'h23: return 0;
      8'h1D: return 1;
      8'h1C: return 2;
      8'h1B: return 3;
      default: return -1;
    endcase
  endfunction

  // One clock with the given inputs; the model follows the same edge.
  task automatic step(input bit kv, input logic [7:0] code, input bit tk,
                      input bit clr, input bit rn);
    int  cidx;
    int  r;
    bit  popping;
    key_valid = kv;
    key_code  = code;
    tick      = tk;
    clear     = clr;
    resetn    = rn;
    @(posedge clk);
    if (!rn || clr) begin
      mq.delete();
      mmov = 3'b000; mmoved = 0; mdropped = 0; mext = 0; mskip = 0;
    end else begin
      cidx = -1;
      if (kv) begin
        if (mskip) begin
          mskip = 0;
        end else if (mext) begin
          mext = 0;
          if (code == 8'hF0) mskip = 1;
          else cidx = arrow_idx(code);
        end else if (code == 8'hE0) begin
          mext = 1;
        end else if (code == 8'hF0) begin
          mskip = 1;
        end else begin
          cidx = wasd_idx(code);
        end
      end
      popping  = tk && (mq.size() > 0);
      r        = (mq.size() > 0) ? int'(mq[$]) : int'(mmov[1:0]);
      mdropped = 0;
      if (popping) mmov = {1'b0, mq.pop_front()};
      // Opposite directions are two steps apart around the compass.
      if (cidx >= 0 && cidx != r && ((cidx - r + 4) % 4) != 2) begin
        if (mq.size() < DEPTH) mq.push_back(cidx[1:0]);
        else mdropped = 1;
      end
      mmoved = popping;
    end
    #1;
    key_valid = 1'b0;
    tick      = 1'b0;
    clear     = 1'b0;
    resetn    = 1'b1;
  endtask

  task automatic send(input logic [7:0] code);
    step(1'b1, code, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_ext(input logic [7:0] code);
    send(8'hE0);
    send(code);
  endtask

  task automatic do_tick();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    key_code = 8'h00; key_valid = 0; tick = 0; clear = 0; resetn = 0;
    do_reset();
    checks++; if (movement !== 3'b000) begin errors++; $display("FAIL reset_movement got %b exp 000", movement); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
    checks++; if (moved !== 1'b0 || dropped !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", moved, dropped); end
  endtask

  task automatic test_basic();
    do_reset();
    send_ext(8'h75);
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL basic_push_qcount got %0d exp 1", q_count); end
    do_tick();
    checks++; if (movement !== 3'b001 || moved !== 1'b1) begin errors++; $display("FAIL basic_pop got mov %b moved %b exp 001 1", movement, moved); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL basic_pop_qcount got %0d exp 0", q_count); end
    do_tick();
    checks++; if (moved !== 1'b0 || movement !== 3'b001) begin errors++; $display("FAIL basic_empty_tick got mov %b moved %b exp 001 0", movement, moved); end
  endtask

  task automatic test_reversal();
    do_reset();
    send_ext(8'h6B);
    checks++; if (q_count !== 3'd0 || dropped !== 1'b0) begin errors++; $display("FAIL rev_reject got q %0d drop %b exp 0 0", q_count, dropped); end
    send_ext(8'h75);
    send_ext(8'h6B);
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL rev_queue got %0d exp 2", q_count); end
    do_tick();
    checks++; if (movement !== 3'b001) begin errors++; $display("FAIL rev_first got %b exp 001", movement); end
    do_tick();
    checks++; if (movement !== 3'b010) begin errors++; $display("FAIL rev_second got %b exp 010", movement); end
    send(8'h23);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rev_wasd_reverse got %0d exp 0", q_count); end
    send(8'h1B);
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL wasd_down got %0d exp 1", q_count); end
  endtask

  task automatic test_prefix();
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL prefix_ext_break got %0d exp 0", q_count); end
    send(8'hF0); send(8'h1D);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL prefix_break got %0d exp 0", q_count); end
    send(8'h75);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL prefix_bare_req got %0d exp 0", q_count); end
    checks++; if (q_count2 !== 3'd1) begin errors++; $display("FAIL prefix_bare_noreq got %0d exp 1", q_count2); end
    do_tick();
    checks++; if (movement2 !== 3'b001) begin errors++; $display("FAIL prefix_bare_noreq_pop got %b exp 001", movement2); end
  endtask

  task automatic test_overflow();
    int obs_drops;
    int exp_drops;
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b000; exp_seq[2] = 3'b001; exp_seq[3] = 3'b000;
    obs_drops = 0;
    exp_drops = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_ext((i % 2 == 0) ? 8'h75 : 8'h74);
      if (dropped) obs_drops++;
      if (mdropped) exp_drops++;
    end
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL ovf_qcount got %0d exp 4", q_count); end
    checks++; if (obs_drops != exp_drops) begin errors++; $display("FAIL ovf_drops got %0d exp %0d", obs_drops, exp_drops); end
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++; if (movement !== exp_seq[i]) begin errors++; $display("FAIL ovf_order idx %0d got %b exp %b", i, movement, exp_seq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) send_ext((i % 2 == 0) ? 8'h75 : 8'h74);
    send(8'hE0);
    step(1'b1, 8'h75, 1'b1, 1'b0, 1'b1);
    checks++; if (q_count !== 3'd4 || dropped !== 1'b0) begin errors++; $display("FAIL simul_full got q %0d drop %b exp 4 0", q_count, dropped); end
    checks++; if (movement !== 3'b001 || moved !== 1'b1) begin errors++; $display("FAIL simul_pop got mov %b moved %b exp 001 1", movement, moved); end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send(8'hE0);
      step(1'b1, (i % 2 == 0) ? 8'h74 : 8'h75, 1'b1, 1'b0, 1'b1);
      checks++; if (movement !== mmov || q_count !== 3'd4) begin errors++; $display("FAIL wrap iter %0d got mov %b q %0d exp %b 4", i, movement, q_count, mmov); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_tick();
      checks++; if (movement !== mmov) begin errors++; $display("FAIL wrap_drain idx %0d got %b exp %b", i, movement, mmov); end
    end
    // Same-edge push and tick on an empty queue only pushes.
    send(8'hE0);
    step(1'b1, (mmov[1:0] == 2'b00) ? 8'h75 : 8'h74, 1'b1, 1'b0, 1'b1);
    checks++; if (q_count !== 3'd1 || moved !== 1'b0) begin errors++; $display("FAIL empty_simul got q %0d moved %b exp 1 0", q_count, moved); end
  endtask

  task automatic test_clear();
    do_reset();
    send_ext(8'h75); send_ext(8'h74); send_ext(8'h75);
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL clear_fill got %0d exp 3", q_count); end
    do_tick();
    send_ext(8'h74);
    send(8'hE0);
    step(1'b1, 8'h72, 1'b1, 1'b1, 1'b1);
    checks++; if (q_count !== 3'd0 || movement !== 3'b000) begin errors++; $display("FAIL clear_state got q %0d mov %b exp 0 000", q_count, movement); end
    checks++; if (moved !== 1'b0 || dropped !== 1'b0) begin errors++; $display("FAIL clear_pulses got %b%b exp 00", moved, dropped); end
    send(8'h74);
    send(8'h75);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL clear_prefix_gone got %0d exp 0", q_count); end
  endtask

  task automatic test_random();
    logic [7:0] pool [11];
    logic [7:0] code;
    bit kv, tk, clr, rn;
    pool = '{8'hE0, 8'hF0, 8'h74, 8'h75, 8'h6B, 8'h72, 8'h23, 8'h1D, 8'h1C, 8'h1B, 8'h00};
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      code = pool[$urandom_range(0, 10)];
      if (code == 8'h00) code = 8'($urandom);
      kv  = ($urandom_range(0, 9) < 7);
      tk  = ($urandom_range(0, 9) < 2);
      clr = ($urandom_range(0, 199) == 0);
      rn  = ($urandom_range(0, 299) != 0);
      step(kv, code, tk, clr, rn);
      checks++; if (movement !== mmov) begin errors++; $display("FAIL rand_movement cyc %0d got %b exp %b", cyc, movement, mmov); end
      checks++; if (q_count !== 3'(mq.size())) begin errors++; $display("FAIL rand_qcount cyc %0d got %0d exp %0d", cyc, q_count, mq.size()); end
      checks++; if (moved !== mmoved) begin errors++; $display("FAIL rand_moved cyc %0d got %b exp %b", cyc, moved, mmoved); end
      checks++; if (dropped !== mdropped) begin errors++; $display("FAIL rand_dropped cyc %0d got %b exp %b", cyc, dropped, mdropped); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reversal();
    test_prefix();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
